// File: rtl/mode_stepper.sv
// mode_stepper: debounced push-button (or stage-done) driven mode counter that
// steps the phase controller through its phases, saturating at MAX_MODE.
module mode_stepper #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_MODE        = 4,
    parameter bit          GATE_ON_DONE    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       stage_done,
    input  logic       auto_en,
    input  logic       clr,
    output logic [2:0] mode_num,
    output logic       mode_change,
    output logic       press_pulse,
    output logic       press_rejected,
    output logic       all_done
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] ModeMax = 3'(MAX_MODE);

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StPressed,
        StReleaseChk
    } deb_state_e;

    deb_state_e      deb_state_q;
    logic [CntW-1:0] cnt_q;
    logic            btn_meta_q;
    logic            btn_sync_q;
    logic            stage_done_q;

    logic            gate_ok;
    logic            press_ok;
    logic            done_rise;
    logic            adv;
    logic            can_step;
    logic [2:0]      mode_d;
    logic            mode_change_d;
    logic            press_rejected_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce FSM: a level must hold DEBOUNCE_CYCLES before it is believed;
    // one press_pulse is issued on each confirmed press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_state_q <= StReleased;
            cnt_q       <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            unique case (deb_state_q)
                StReleased: begin
                    if (btn_sync_q) begin
                        deb_state_q <= StPressChk;
                        cnt_q       <= '0;
                    end
                end
                StPressChk: begin
                    if (!btn_sync_q) begin
                        deb_state_q <= StReleased;
                    end else if (cnt_q == CntLast) begin
                        deb_state_q <= StPressed;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!btn_sync_q) begin
                        deb_state_q <= StReleaseChk;
                        cnt_q       <= '0;
                    end
                end
                StReleaseChk: begin
                    // A bounce back high returns to Pressed without a new pulse.
                    if (btn_sync_q) begin
                        deb_state_q <= StPressed;
                    end else if (cnt_q == CntLast) begin
                        deb_state_q <= StReleased;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Next-mode decode: clear wins over advance; press and auto advance in the
    // same cycle merge into a single step.
    always_comb begin
        gate_ok          = (GATE_ON_DONE == 1'b0) || stage_done || (mode_num == 3'd0);
        press_ok         = press_pulse && gate_ok;
        done_rise        = stage_done && !stage_done_q;
        adv              = press_ok || (auto_en && done_rise);
        can_step         = (mode_num < ModeMax);
        mode_d           = mode_num;
        mode_change_d    = 1'b0;
        press_rejected_d = press_pulse && (clr || !gate_ok || !can_step);
        if (clr) begin
            mode_d        = 3'd0;
            mode_change_d = (mode_num != 3'd0);
        end else if (adv && can_step) begin
            mode_d        = mode_num + 3'd1;
            mode_change_d = 1'b1;
        end
    end

    // Registered mode state, strobes and the done edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_num       <= 3'd0;
            mode_change    <= 1'b0;
            press_rejected <= 1'b0;
            all_done       <= 1'b0;
            stage_done_q   <= 1'b0;
        end else begin
            mode_num       <= mode_d;
            mode_change    <= mode_change_d;
            press_rejected <= press_rejected_d;
            all_done       <= (mode_d == ModeMax);
            stage_done_q   <= clr ? 1'b0 : stage_done;
        end
    end

endmodule

// File: tb/tb_mode_stepper.sv
// Self-checking bench for mode_stepper: scoreboard of expected mode events plus
// directed cycle-exact checks of debounce latency.
module tb_mode_stepper;

    localparam int unsigned Deb = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       stage_done;
    logic       auto_en;
    logic       clr;
    logic [2:0] mode_num;
    logic       mode_change;
    logic       press_pulse;
    logic       press_rejected;
    logic       all_done;

    typedef struct packed {
        logic [2:0] mode;
        logic       chg;
        logic       rej;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;

    mode_stepper #(
        .DEBOUNCE_CYCLES(Deb),
        .MAX_MODE       (4),
        .GATE_ON_DONE   (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .stage_done    (stage_done),
        .auto_en       (auto_en),
        .clr           (clr),
        .mode_num      (mode_num),
        .mode_change   (mode_change),
        .press_pulse   (press_pulse),
        .press_rejected(press_rejected),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] m, input logic c, input logic r, input logic d);
        exp_t e;
        e.mode = m;
        e.chg  = c;
        e.rej  = r;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press held well past the debounce window, then released and settled.
    task automatic clean_press();
        btn_raw = 1'b1;
        cyc(10);
        btn_raw = 1'b0;
        cyc(10);
    endtask

    // Scoreboard: every mode_change / press_rejected cycle consumes one entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (press_pulse) pulse_cnt++;
            if (mode_change || press_rejected) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_event", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_mode", 32'(mode_num), 32'(e.mode));
                    check_eq("sb_mode_change", 32'(mode_change), 32'(e.chg));
                    check_eq("sb_press_rejected", 32'(press_rejected), 32'(e.rej));
                    check_eq("sb_all_done", 32'(all_done), 32'(e.done));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        btn_raw    = 1'b0;
        stage_done = 1'b0;
        auto_en    = 1'b0;
        clr        = 1'b0;
        #12;
        check_eq("rst_mode", 32'(mode_num), 32'd0);
        check_eq("rst_chg", 32'(mode_change), 32'd0);
        check_eq("rst_pulse", 32'(press_pulse), 32'd0);
        check_eq("rst_rej", 32'(press_rejected), 32'd0);
        check_eq("rst_all_done", 32'(all_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // 1: held press, exact pulse timing, no repeat while held
        push_exp(3'd1, 1'b1, 1'b0, 1'b0);
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("t1_pulse", 32'(press_pulse), 32'(i == 6));
            if (i == 7) begin
                check_eq("t1_mode", 32'(mode_num), 32'd1);
                check_eq("t1_chg", 32'(mode_change), 32'd1);
            end
        end
        btn_raw = 1'b0;
        cyc(10);
        check_eq("t1_one_pulse", 32'(pulse_cnt), 32'd1);

        // 2: bouncing input shorter than the debounce window
        btn_raw = 1'b1; cyc(3);
        btn_raw = 1'b0; cyc(1);
        btn_raw = 1'b1; cyc(3);
        btn_raw = 1'b0; cyc(12);
        check_eq("t2_no_pulse", 32'(pulse_cnt), 32'd1);
        check_eq("t2_mode", 32'(mode_num), 32'd1);

        // 3: gating on stage_done
        stage_done = 1'b0;
        push_exp(3'd1, 1'b0, 1'b1, 1'b0);
        clean_press();
        check_eq("t3_gated_mode", 32'(mode_num), 32'd1);
        stage_done = 1'b1;
        push_exp(3'd2, 1'b1, 1'b0, 1'b0);
        clean_press();
        check_eq("t3_open_mode", 32'(mode_num), 32'd2);

        // 4: clear, then auto advance up to saturation
        stage_done = 1'b0;
        cyc(2);
        push_exp(3'd0, 1'b1, 1'b0, 1'b0);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check_eq("t4_clr_mode", 32'(mode_num), 32'd0);
        auto_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) push_exp(3'(k), 1'b1, 1'b0, k == 4);
            stage_done = 1'b1;
            cyc(2);
            stage_done = 1'b0;
            cyc(2);
        end
        check_eq("t4_sat_mode", 32'(mode_num), 32'd4);
        check_eq("t4_all_done", 32'(all_done), 32'd1);

        // 5: press at saturation, then clear coincident with a press pulse
        auto_en    = 1'b0;
        stage_done = 1'b1;
        push_exp(3'd4, 1'b0, 1'b1, 1'b1);
        clean_press();
        check_eq("t5_sat_hold", 32'(mode_num), 32'd4);
        push_exp(3'd0, 1'b1, 1'b1, 1'b0);
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clr = 1'b0;
            if (i == 6) begin
                check_eq("t5_pulse", 32'(press_pulse), 32'd1);
                clr = 1'b1;
            end
            if (i == 7) begin
                check_eq("t5_clr_mode", 32'(mode_num), 32'd0);
                check_eq("t5_all_done", 32'(all_done), 32'd0);
            end
        end
        btn_raw = 1'b0;
        cyc(10);

        // 6: async reset mid debounce at mode 3, button held across release
        for (int k = 1; k <= 3; k++) begin
            push_exp(3'(k), 1'b1, 1'b0, 1'b0);
            clean_press();
        end
        check_eq("t6_pre_mode", 32'(mode_num), 32'd3);
        btn_raw = 1'b1;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_mode", 32'(mode_num), 32'd0);
        check_eq("t6_rst_chg", 32'(mode_change), 32'd0);
        check_eq("t6_rst_pulse", 32'(press_pulse), 32'd0);
        check_eq("t6_rst_rej", 32'(press_rejected), 32'd0);
        check_eq("t6_rst_all_done", 32'(all_done), 32'd0);
        cyc(2);
        push_exp(3'd1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t6_pulse", 32'(press_pulse), 32'(i == 6));
            if (i == 7) check_eq("t6_mode", 32'(mode_num), 32'd1);
        end
        btn_raw = 1'b0;
        cyc(10);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode_stepper.md
Name: mode_stepper

Overview:
- Upstream feeder of the phase controller: produces the 3-bit mode_num that steps the controller through memory load, single PE, 3x3 array, 2x2 array and display phases.
- Synchronises and debounces a raw push-button input.
- Converts each debounced press into a one-step mode increment, saturating at MAX_MODE.
- Optionally gates presses on the active stage's completion flag, or auto-advances on that flag.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles btn must be stable (≥1); 10 ms at 100 MHz
MAX_MODE, 4, terminal mode_num value (1..7)
GATE_ON_DONE, 1, 1: press accepted only while stage_done=1 (except at mode 0); 0: presses always accepted

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
btn_raw  in  1  raw push button, asynchronous to clk, active-high
stage_done  in  1  completion level from currently enabled stage
auto_en  in  1  1: advance on rising edge of stage_done without press
clr  in  1  synchronous soft clear of mode_num
mode_num  out  3  current mode, 0..MAX_MODE
mode_change  out  1  one-cycle strobe, high in first cycle of new mode_num
press_pulse  out  1  one-cycle debounced press strobe
press_rejected  out  1  one-cycle strobe: press dropped (gated or saturated)
all_done  out  1  mode_num == MAX_MODE

Behaviour:
- Reset (async): sync FFs, counter, FSM=RELEASED, mode_num=0, all strobes 0, all_done=0, stage_done edge register=0. Reset mid-debounce or mid-step aborts everything; a button held across reset release is treated as a fresh press.
- Synchroniser: 2-FF chain on btn_raw → btn_sync.
- Debounce FSM. Counter cnt is ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - RELEASED: btn_sync=1 → PRESS_CHK, cnt=0.
  - PRESS_CHK: btn_sync=0 → RELEASED. Else if cnt==DEBOUNCE_CYCLES-1 → PRESSED with press_pulse=1 next cycle. Else cnt+1.
  - PRESSED: btn_sync=0 → RELEASE_CHK, cnt=0.
  - RELEASE_CHK: btn_sync=1 → PRESSED (no new pulse). Else if cnt==DEBOUNCE_CYCLES-1 → RELEASED. Else cnt+1.
- Press latency: if btn_raw is first sampled high at edge k and held, press_pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2. Exactly one pulse per press; glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Done edge: done_rise = stage_done & ~stage_done_q (registered).
- Advance request: adv = press_ok | (auto_en & done_rise).
  - press_ok = press_pulse & (GATE_ON_DONE==0 | stage_done | mode_num==0).
- Mode update, evaluated at each edge in this priority:
  1. clr → mode_num=0; mode_change=1 if mode_num was ≠0; done edge register cleared.
  2. adv & mode_num<MAX_MODE → mode_num+1, mode_change=1.
  3. Otherwise hold.
- Press-to-mode latency: mode_num changes on the edge after press_pulse is high, i.e. 1 cycle.
- Simultaneous press and auto advance in one cycle: single increment only.
- press_rejected=1 for one cycle when press_pulse=1 and the press is not accepted. Causes: gate fails, mode_num==MAX_MODE, or clr asserted that cycle.
- Saturation: at MAX_MODE no increment and no mode_change; all_done stays 1 until clr or rst.
- mode_num never exceeds MAX_MODE and never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (bench DEBOUNCE_CYCLES=4, MAX_MODE=4, GATE_ON_DONE=1):
1. Reset, then btn_raw rises before edge 0 and is held 20 cycles → press_pulse high only in the cycle after edge 6; mode_num 0→1 at edge 7 with mode_change=1 for that cycle; no second pulse while held.
2. Bounce: btn_raw high 3 cycles, low 1, high 3, then low → no press_pulse, mode_num unchanged.
3. Gating: mode_num=1, stage_done=0, clean press → press_rejected one cycle, mode_num stays 1. Repeat with stage_done=1 → mode_num=2.
4. Auto: auto_en=1, stage_done toggles 0→1 four times from mode 0 → mode_num 1,2,3,4; further rises give no change; all_done=1.
5. Saturation and clear: at mode 4, accepted-looking press → press_rejected=1. Then clr=1 with a coincident press_pulse → mode_num=0, mode_change=1, press_rejected=1, all_done=0.
6. Async rst asserted mid-PRESS_CHK at mode 3 → all outputs 0 immediately. Button still held after release → one press_pulse DEBOUNCE_CYCLES+2 edges later, mode_num=1.
